// File: rtl/can_tx_bit_stuffer.sv
// CAN transmit bit stuffer: drives the TX line, inserts a complement bit after
// STUFF_LIMIT equal bits and checks the read-back bus for bit errors / arbitration loss.
module can_tx_bit_stuffer #(
    parameter int STUFF_LIMIT = 5,
    parameter int SCNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_start_point,
    input  logic              sample_point,
    input  logic              tx_bit_in,
    input  logic              bit_stuffing_en,
    input  logic              arbitration_active,
    input  logic              ack_slot,
    input  logic              rx_bit,
    output logic              can_tx,
    output logic              insert_stuff_bit,
    output logic              bit_error,
    output logic              arbitration_lost,
    output logic [SCNT_W-1:0] stuff_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        STUFF = 3'd2,
        TAIL  = 3'd3,
        LOST  = 3'd4
    } state_t;

    localparam logic [2:0] LIMIT     = 3'(STUFF_LIMIT);
    localparam logic [3:0] TAIL_BITS = 4'd11;

    state_t     state;
    logic [2:0] run_cnt;
    logic       last_bit;
    logic [3:0] tail_cnt;
    logic       stuff_on_line;
    logic [2:0] run_next;
    logic       monitored;
    logic       overwritten;
    logic       mismatch;

    assign run_next    = (tx_bit_in == last_bit) ? run_cnt + 3'd1 : 3'd1;
    assign monitored   = (state == RUN) || (state == STUFF) || (state == TAIL);
    assign overwritten = can_tx & ~rx_bit;
    assign mismatch    = can_tx ^ rx_bit;

    // Stall handshake: while insert_stuff_bit is high the upstream FSM holds
    // tx_bit_in and its own state; the bit_start_point that closes the STUFF
    // bit time launches the stuff bit and the held bit goes out one bit later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            can_tx           <= 1'b1;
            insert_stuff_bit <= 1'b0;
            bit_error        <= 1'b0;
            arbitration_lost <= 1'b0;
            stuff_cnt        <= '0;
            run_cnt          <= 3'd0;
            last_bit         <= 1'b1;
            tail_cnt         <= 4'd0;
            stuff_on_line    <= 1'b0;
        end else begin
            bit_error        <= 1'b0;
            arbitration_lost <= 1'b0;
            if (bit_start_point) begin
                stuff_on_line <= 1'b0;
                case (state)
                    IDLE, TAIL: begin
                        if (bit_stuffing_en) begin
                            state     <= RUN;
                            can_tx    <= tx_bit_in;
                            last_bit  <= tx_bit_in;
                            run_cnt   <= 3'd1;
                            stuff_cnt <= '0;
                            tail_cnt  <= 4'd0;
                        end else if (state == IDLE) begin
                            can_tx  <= 1'b1;
                            run_cnt <= 3'd0;
                        end else begin
                            can_tx <= tx_bit_in;
                            if (!tx_bit_in) begin
                                tail_cnt <= 4'd0;
                            end else if (tail_cnt == TAIL_BITS - 4'd1) begin
                                tail_cnt <= 4'd0;
                                state    <= IDLE;
                            end else begin
                                tail_cnt <= tail_cnt + 4'd1;
                            end
                        end
                    end
                    RUN: begin
                        can_tx   <= tx_bit_in;
                        last_bit <= tx_bit_in;
                        if (bit_stuffing_en) begin
                            run_cnt <= run_next;
                            if (run_next == LIMIT) begin
                                state            <= STUFF;
                                insert_stuff_bit <= 1'b1;
                            end
                        end else begin
                            run_cnt  <= 3'd0;
                            tail_cnt <= 4'd0;
                            state    <= TAIL;
                        end
                    end
                    STUFF: begin
                        can_tx           <= ~last_bit;
                        last_bit         <= ~last_bit;
                        run_cnt          <= 3'd1;
                        stuff_on_line    <= 1'b1;
                        insert_stuff_bit <= 1'b0;
                        tail_cnt         <= 4'd0;
                        if (stuff_cnt != '1) stuff_cnt <= stuff_cnt + SCNT_W'(1);
                        state <= bit_stuffing_en ? RUN : TAIL;
                    end
                    LOST: begin
                        can_tx <= 1'b1;
                        if (!bit_stuffing_en) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (sample_point && monitored && mismatch) begin
                // A stuff bit on the line is never an arbitration bit, even inside the ID field.
                if (overwritten && arbitration_active && !stuff_on_line) begin
                    arbitration_lost <= 1'b1;
                    insert_stuff_bit <= 1'b0;
                    state            <= LOST;
                end else if (!(overwritten && ack_slot)) begin
                    bit_error        <= 1'b1;
                    insert_stuff_bit <= 1'b0;
                    state            <= LOST;
                end
            end
        end
    end

endmodule

// File: tb/tb_can_tx_bit_stuffer.sv
// Bench for can_tx_bit_stuffer: table of bit-time records (inputs plus expected
// line/stall/pulse values) fed through a scoreboard queue, plus an async-reset sequence.
module tb_can_tx_bit_stuffer;

    logic       clk;
    logic       rst_n;
    logic       bit_start_point;
    logic       sample_point;
    logic       tx_bit_in;
    logic       bit_stuffing_en;
    logic       arbitration_active;
    logic       ack_slot;
    logic       rx_bit;
    logic       rx_force;
    logic       can_tx;
    logic       insert_stuff_bit;
    logic       bit_error;
    logic       arbitration_lost;
    logic [7:0] stuff_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int   tid;
        logic tx, en, arb, ack, frc;
        logic etx, eins, ebe, eal;
        int   scnt;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] exp_q[$];

    can_tx_bit_stuffer #(.STUFF_LIMIT(5), .SCNT_W(8)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .bit_start_point    (bit_start_point),
        .sample_point       (sample_point),
        .tx_bit_in          (tx_bit_in),
        .bit_stuffing_en    (bit_stuffing_en),
        .arbitration_active (arbitration_active),
        .ack_slot           (ack_slot),
        .rx_bit             (rx_bit),
        .can_tx             (can_tx),
        .insert_stuff_bit   (insert_stuff_bit),
        .bit_error          (bit_error),
        .arbitration_lost   (arbitration_lost),
        .stuff_cnt          (stuff_cnt)
    );

    // Bus loopback; rx_force models another node driving dominant.
    assign rx_bit = rx_force ? 1'b0 : can_tx;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input int tid, input logic tx, en, arb, ack, frc,
                                input logic etx, eins, ebe, eal, input int scnt);
        vec_t v;
        v.tid = tid; v.tx = tx; v.en = en; v.arb = arb; v.ack = ack; v.frc = frc;
        v.etx = etx; v.eins = eins; v.ebe = ebe; v.eal = eal; v.scnt = scnt;
        return v;
    endfunction

    task automatic push_ones(input int tid, input int n, input int scnt_last);
        for (int i = 0; i < n; i++)
            vecs.push_back(mk(tid, 1, 0, 0, 0, 0, 1, 0, 0, 0, (i == n - 1) ? scnt_last : -1));
    endtask

    // One bit time: launch at bit_start_point, sample 3 clks later, check pulses.
    task automatic apply_vec(input vec_t v, input int idx);
        logic       t_tx, t_ins;
        logic [3:0] exp;
        exp_q.push_back({v.etx, v.eins, v.ebe, v.eal});
        @(negedge clk);
        tx_bit_in = v.tx; bit_stuffing_en = v.en; arbitration_active = v.arb;
        ack_slot = v.ack; bit_start_point = 1'b1;
        @(negedge clk);
        bit_start_point = 1'b0;
        t_tx  = can_tx;
        t_ins = insert_stuff_bit;
        @(negedge clk);
        @(negedge clk);
        rx_force = v.frc; sample_point = 1'b1;
        @(negedge clk);
        sample_point = 1'b0;
        exp = exp_q.pop_front();
        check($sformatf("t%0d tx/ins/berr/alost", v.tid), idx,
              32'({t_tx, t_ins, bit_error, arbitration_lost}), 32'(exp));
        @(negedge clk);
        rx_force = 1'b0;
        check($sformatf("t%0d pulse width", v.tid), idx, 32'({bit_error, arbitration_lost}), 32'd0);
        if (v.scnt >= 0) check($sformatf("t%0d stuff_cnt", v.tid), idx, 32'(stuff_cnt), 32'(v.scnt));
    endtask

    task automatic run_table();
        int n = 0;
        while (vecs.size() > 0) begin
            apply_vec(vecs.pop_front(), n);
            n++;
        end
    endtask

    initial begin
        logic r_last, pending, b;
        int   r_run, nstuff;

        rst_n = 1'b0; bit_start_point = 1'b0; sample_point = 1'b0; tx_bit_in = 1'b1;
        bit_stuffing_en = 1'b0; arbitration_active = 1'b0; ack_slot = 1'b0; rx_force = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", 0, 32'({can_tx, insert_stuff_bit, bit_error, arbitration_lost}), 32'b1000);
        check("reset stuff_cnt", 0, 32'(stuff_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: 1,00000 -> stuff 1; then tail boundary (10 ones then 0 stays in TAIL, 11 ones -> IDLE)
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, -1));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, -1));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, -1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, -1));
        push_ones(1, 10, 1);
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1));
        push_ones(1, 11, -1);
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, -1));
        // T2: 00000 s1 1111 s0, then 0000 into another STUFF (reset lands there)
        vecs.push_back(mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, -1));
        vecs.push_back(mk(2, 0, 1, 0, 0, 0, 0, 1, 0, 0, -1));
        vecs.push_back(mk(2, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(2, 1, 1, 0, 0, 0, 1, 0, 0, 0, -1));
        vecs.push_back(mk(2, 1, 1, 0, 0, 0, 1, 1, 0, 0, -1));
        vecs.push_back(mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, -1));
        vecs.push_back(mk(2, 0, 1, 0, 0, 0, 0, 1, 0, 0, 2));
        run_table();

        // T6: asynchronous reset while in STUFF with a dominant line
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6 async can_tx/ins", 0, 32'({can_tx, insert_stuff_bit}), 32'b10);
        check("t6 async stuff_cnt", 0, 32'(stuff_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bit_stuffing_en = 1'b0;

        // T3: CRC ends in 11111, en drops; trailing stuff 0, delimiter delayed
        vecs.push_back(mk(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(3, 1, 1, 0, 0, 0, 1, 0, 0, 0, -1));
        vecs.push_back(mk(3, 1, 1, 0, 0, 0, 1, 1, 0, 0, -1));
        vecs.push_back(mk(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        push_ones(3, 11, 1);
        vecs.push_back(mk(3, 0, 0, 0, 0, 0, 1, 0, 0, 0, -1));
        // T4: arbitration loss -> LOST holds recessive until en drops
        vecs.push_back(mk(4, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4, 1, 1, 1, 0, 1, 1, 0, 0, 1, -1));
        vecs.push_back(mk(4, 0, 1, 1, 0, 0, 1, 0, 0, 0, -1));
        vecs.push_back(mk(4, 0, 1, 0, 0, 0, 1, 0, 0, 0, -1));
        vecs.push_back(mk(4, 0, 0, 0, 0, 0, 1, 0, 0, 0, -1));
        // T5: ACK slot override is legal; same mismatch outside it is a bit error
        vecs.push_back(mk(5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(5, 1, 1, 0, 0, 0, 1, 0, 0, 0, -1));
        vecs.push_back(mk(5, 1, 0, 0, 0, 0, 1, 0, 0, 0, -1));
        vecs.push_back(mk(5, 1, 0, 0, 1, 1, 1, 0, 0, 0, -1));
        vecs.push_back(mk(5, 1, 0, 0, 0, 1, 1, 0, 1, 0, -1));
        vecs.push_back(mk(5, 0, 0, 0, 0, 0, 1, 0, 0, 0, -1));
        // T7: stuff bit overwritten during arbitration is a bit error
        vecs.push_back(mk(7, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(7, 0, 1, 1, 0, 0, 0, 0, 0, 0, -1));
        vecs.push_back(mk(7, 0, 1, 1, 0, 0, 0, 1, 0, 0, -1));
        vecs.push_back(mk(7, 0, 1, 1, 0, 1, 1, 0, 1, 0, -1));
        vecs.push_back(mk(7, 0, 0, 0, 0, 0, 1, 0, 0, 0, -1));

        // T8: random run-heavy frame, expectations from a reference stuffing model
        b = 1'b0;
        vecs.push_back(mk(8, b, 1, 0, 0, 0, b, 0, 0, 0, 0));
        r_last = b; r_run = 1; pending = 1'b0; nstuff = 0;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) b = ~b;
            if (pending) begin
                vecs.push_back(mk(8, b, 1, 0, 0, 0, ~r_last, 0, 0, 0, -1));
                r_last = ~r_last; r_run = 1; pending = 1'b0; nstuff++;
            end
            r_run  = (b == r_last) ? r_run + 1 : 1;
            r_last = b;
            pending = (r_run == 5);
            vecs.push_back(mk(8, b, 1, 0, 0, 0, b, pending, 0, 0, -1));
        end
        if (pending) begin
            vecs.push_back(mk(8, 1, 0, 0, 0, 0, ~r_last, 0, 0, 0, -1));
            nstuff++;
        end
        push_ones(8, 12, nstuff);
        run_table();

        check("scoreboard drained", 0, 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
